// File: rtl/fifo2audpwm_pkg.sv
// Shared types and helpers for the FIFO-to-PWM audio path.
// FSM states, PCM midscale constant and offset-binary conversion.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    CAPTURE
  } aud_state_e;

  localparam logic [15:0] SAMPLE_MIDSCALE = 16'h0000;

  // Flipping the sign bit maps two's complement onto offset binary.
  function automatic logic [31:0] to_offset(
    input logic [31:0] s,
    input int unsigned w
  );
    return s ^ (32'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/fifo2audpwm_if.sv
// FIFO read port between the audio FIFO and its consumer.
// master = reader (drives fifo_rd_en), slave = FIFO.
interface fifo2audpwm_if #(
  parameter int FIFO_DATA_WIDTH = 32
);
  logic [FIFO_DATA_WIDTH-1:0] fifo_rd_data;
  logic                       fifo_empty;
  logic                       fifo_rd_en;

  modport master (
    input  fifo_rd_data,
    input  fifo_empty,
    output fifo_rd_en
  );

  modport slave (
    output fifo_rd_data,
    output fifo_empty,
    input  fifo_rd_en
  );
endinterface

// File: rtl/fifo2audpwm_dac.sv
// PWM DAC: free-running counter, wrap-latched duty, registered output.
module audio_pwm_dac #(
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [PWM_WIDTH-1:0] duty,
  input  logic                 enable,
  output logic                 aud_pwm
);

  localparam logic [PWM_WIDTH-1:0] MID =
    PWM_WIDTH'(1) << (PWM_WIDTH - 1);

  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic [PWM_WIDTH-1:0] duty_q;

  // duty_q only moves at the period boundary so no period is split.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_cnt <= '0;
      duty_q  <= MID;
      aud_pwm <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (&pwm_cnt) duty_q <= duty;
      aud_pwm <= enable && (pwm_cnt < duty_q);
    end
  end

endmodule

// File: rtl/fifo2audpwm.sv
// Paced FIFO reader driving a mono PWM audio output.
// FIFO2AUDPWM_UNDERRUN_CNT_EN adds a saturating underrun_count port.
module fifo2audpwm
  import audio_pkg::*;
#(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int SAMPLE_DIV      = 2268,
  parameter int FIFO_RD_LATENCY = 1,
  parameter int PWM_WIDTH       = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          enable,
  fifo2audpwm_if.master fifo,
  output logic          aud_pwm,
  output logic          aud_sd,
  output logic          underrun
`ifdef FIFO2AUDPWM_UNDERRUN_CNT_EN
  ,
  output logic [15:0]   underrun_count
`endif
);

  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int WCNT_W = $clog2(FIFO_RD_LATENCY + 1);
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(SAMPLE_DIV - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST =
    WCNT_W'(FIFO_RD_LATENCY - 2);

  logic [DIV_W-1:0]        div_cnt;
  logic                    tick;
  aud_state_e              state_q;
  aud_state_e              state_d;
  logic [WCNT_W-1:0]       wcnt_q;
  logic [WCNT_W-1:0]       wcnt_d;
  logic                    rd_en;
  logic                    cap;
  logic                    ur_evt;
  logic [SAMPLE_WIDTH-1:0] sample_q;
  logic [SAMPLE_WIDTH-1:0] u;
  logic [PWM_WIDTH-1:0]    duty;
  logic                    unused_bits;

  assign tick = enable && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt <= '0;
    end else if (!enable || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // A started read always runs to CAPTURE, even if enable drops.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rd_en   = 1'b0;
    cap     = 1'b0;
    ur_evt  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          if (fifo.fifo_empty) ur_evt = 1'b1;
          else state_d = READ;
        end
      end
      READ: begin
        rd_en   = 1'b1;
        wcnt_d  = '0;
        state_d = (FIFO_RD_LATENCY > 1) ? WAIT : CAPTURE;
      end
      WAIT: begin
        if (wcnt_q == WAIT_LAST) state_d = CAPTURE;
        else wcnt_d = wcnt_q + 1'b1;
      end
      CAPTURE: begin
        cap     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo.fifo_rd_en = rd_en;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sample_q <= SAMPLE_WIDTH'(SAMPLE_MIDSCALE);
      underrun <= 1'b0;
      aud_sd   <= 1'b0;
    end else begin
      if (cap) sample_q <= fifo.fifo_rd_data[SAMPLE_WIDTH-1:0];
      underrun <= ur_evt;
      aud_sd   <= enable;
    end
  end

  assign u = SAMPLE_WIDTH'(to_offset(32'(sample_q), SAMPLE_WIDTH));
  assign duty = u[SAMPLE_WIDTH-1 -: PWM_WIDTH];

  assign unused_bits = ^{
    u[SAMPLE_WIDTH-PWM_WIDTH-1:0],
    fifo.fifo_rd_data[FIFO_DATA_WIDTH-1:SAMPLE_WIDTH]
  };

`ifdef FIFO2AUDPWM_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ucnt_q <= '0;
    end else if (ur_evt && (ucnt_q != 16'hFFFF)) begin
      ucnt_q <= ucnt_q + 16'd1;
    end
  end

  assign underrun_count = ucnt_q;
`endif

  audio_pwm_dac #(
    .PWM_WIDTH(PWM_WIDTH)
  ) u_dac (
    .clk    (clk),
    .resetn (resetn),
    .duty   (duty),
    .enable (enable),
    .aud_pwm(aud_pwm)
  );

endmodule

// File: tb/tb_fifo2audpwm.sv
// Bench for fifo2audpwm: latency-1 and latency-3 instances,
// FIFO models, cycle-indexed history and directed checks.
module tb_fifo2audpwm;
  import audio_pkg::*;

  typedef struct {
    logic [15:0] data;
    int          exp_duty;
  } vec_t;

  localparam logic [31:0] JUNK = 32'h5A5A_8000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic enable = 1'b0;
  logic aud_pwm1, aud_sd1, underrun1;
  logic aud_pwm3, aud_sd3, underrun3;
`ifdef FIFO2AUDPWM_UNDERRUN_CNT_EN
  logic [15:0] ucnt1, ucnt3;
`endif

  fifo2audpwm_if #(.FIFO_DATA_WIDTH(32)) f1();
  fifo2audpwm_if #(.FIFO_DATA_WIDTH(32)) f3();

  fifo2audpwm #(
    .FIFO_DATA_WIDTH(32), .SAMPLE_WIDTH(16),
    .SAMPLE_DIV(16), .FIFO_RD_LATENCY(1), .PWM_WIDTH(4)
  ) dut1 (
    .clk(clk), .resetn(resetn), .enable(enable),
    .fifo(f1), .aud_pwm(aud_pwm1), .aud_sd(aud_sd1),
    .underrun(underrun1)
`ifdef FIFO2AUDPWM_UNDERRUN_CNT_EN
    , .underrun_count(ucnt1)
`endif
  );

  fifo2audpwm #(
    .FIFO_DATA_WIDTH(32), .SAMPLE_WIDTH(16),
    .SAMPLE_DIV(16), .FIFO_RD_LATENCY(3), .PWM_WIDTH(4)
  ) dut3 (
    .clk(clk), .resetn(resetn), .enable(enable),
    .fifo(f3), .aud_pwm(aud_pwm3), .aud_sd(aud_sd3),
    .underrun(underrun3)
`ifdef FIFO2AUDPWM_UNDERRUN_CNT_EN
    , .underrun_count(ucnt3)
`endif
  );

  always #5 clk = ~clk;

  // FIFO models: data appears LATENCY cycles after the read strobe.
  logic [31:0] mem1 [16];
  logic [31:0] mem3 [16];
  logic [3:0]  rp1, wp1, rp3, wp3;
  logic [31:0] s1;
  logic [31:0] p3 [3];

  always @(posedge clk) begin
    if (!resetn) rp1 <= '0;
    else if (f1.fifo_rd_en) rp1 <= rp1 + 4'd1;
    if (!resetn) rp3 <= '0;
    else if (f3.fifo_rd_en) rp3 <= rp3 + 4'd1;
    s1 <= f1.fifo_rd_en ? mem1[rp1] : JUNK;
    p3[0] <= f3.fifo_rd_en ? mem3[rp3] : JUNK;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign f1.fifo_rd_data = s1;
  assign f1.fifo_empty   = (rp1 == wp1);
  assign f3.fifo_rd_data = p3[2];
  assign f3.fifo_empty   = (rp3 == wp3);

  int cyc;
  int checks = 0;
  int failures = 0;
  bit h1 [0:255];
  bit h3 [0:255];
  bit sd1 [0:255];
  int rd1 [$];
  int rd3 [$];
  int ur1 [$];
  vec_t vec [8];

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d",
               name, act, exp);
    end
  endtask

  task automatic record();
    h1[cyc]  = aud_pwm1;
    h3[cyc]  = aud_pwm3;
    sd1[cyc] = aud_sd1;
    if (f1.fifo_rd_en) rd1.push_back(cyc);
    if (f3.fifo_rd_en) rd3.push_back(cyc);
    if (underrun1) ur1.push_back(cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    record();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst rd_en1", int'(f1.fifo_rd_en), 0);
    chk("rst pwm1", int'(aud_pwm1), 0);
    chk("rst sd1", int'(aud_sd1), 0);
    chk("rst ur1", int'(underrun1), 0);
    chk("rst rd_en3", int'(f3.fifo_rd_en), 0);
    wp1 = '0;
    wp3 = '0;
    rd1.delete();
    rd3.delete();
    ur1.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc = 0;
    record();
  endtask

  task automatic push1(input logic [31:0] w);
    mem1[wp1] = w;
    wp1 = wp1 + 4'd1;
  endtask

  task automatic push3(input logic [31:0] w);
    mem3[wp3] = w;
    wp3 = wp3 + 4'd1;
  endtask

  function automatic int win(input bit use3, input int a,
                             input int b);
    int n = 0;
    for (int c = a; c <= b; c++)
      n += use3 ? int'(h3[c]) : int'(h1[c]);
    return n;
  endfunction

  function automatic int at(input int q [$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  initial begin
    vec[0] = '{16'h0000, 8};
    vec[1] = '{16'h7FFF, 15};
    vec[2] = '{16'h8000, 0};
    vec[3] = '{16'h4000, 12};
    vec[4] = '{16'hC000, 4};
    vec[5] = '{16'hFFFF, 7};
    vec[6] = '{16'h0FFF, 8};
    vec[7] = '{16'h1234, 9};

    // Phase A: streaming, underrun hold/resume, latency 3
    do_reset();
    for (int i = 0; i < 8; i++)
      push1({16'hBEE0 | 16'(i), vec[i].data});
    push3(32'hABCD_7FFF);
    run_to(170);
    push1(32'h0000_4000);
    run_to(215);

    chk("A sd on", int'(sd1[5]), 1);
    chk("A mid win0", win(0, 1, 16), 8);
    chk("A mid win1", win(0, 17, 32), 8);
    chk("A rd count", rd1.size(), 9);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("A rd%0d", k), at(rd1, k), 16 + 16 * k);
      chk($sformatf("A duty%0d", k),
          win(0, 33 + 16 * k, 48 + 16 * k), vec[k].exp_duty);
    end
    chk("A ur count", ur1.size(), 4);
    chk("A ur0", at(ur1, 0), 144);
    chk("A ur1", at(ur1, 1), 160);
    chk("A ur2", at(ur1, 2), 192);
    chk("A hold", win(0, 161, 176), vec[7].exp_duty);
    chk("A refill rd", at(rd1, 8), 176);
    chk("A refill duty", win(0, 193, 208), 12);
    chk("L3 rd count", rd3.size(), 1);
    chk("L3 rd", at(rd3, 0), 16);
    chk("L3 pre-wrap", win(1, 17, 32), 8);
    chk("L3 duty", win(1, 33, 48), 15);

    // Phase B: enable drops one cycle after the read strobe
    do_reset();
    push1(32'h0000_7FFF);
    push1(32'h1111_8000);
    run_to(17);
    enable = 1'b0;
    run_to(48);
    enable = 1'b1;
    run_to(100);

    chk("B sd17", int'(sd1[17]), 1);
    chk("B sd18", int'(sd1[18]), 0);
    chk("B pwm off", win(0, 18, 48), 0);
    chk("B rd count", rd1.size(), 2);
    chk("B rd0", at(rd1, 0), 16);
    chk("B rd1", at(rd1, 1), 64);
    chk("B captured", win(0, 49, 64), 15);
    chk("B next duty", win(0, 81, 96), 0);

    // Phase C: reset asserted while dut3 waits on read data
    do_reset();
    push3(32'h0000_7FFF);
    run_to(17);
    chk("C pre pwm3", int'(h3[17]), 1);
    resetn = 1'b0;
    #1;
    chk("C rst rd_en3", int'(f3.fifo_rd_en), 0);
    chk("C rst pwm3", int'(aud_pwm3), 0);
    chk("C rst sd3", int'(aud_sd3), 0);
    chk("C rst ur3", int'(underrun3), 0);
    do_reset();
    push3(32'h0000_C000);
    run_to(50);
`ifdef FIFO2AUDPWM_UNDERRUN_CNT_EN
    chk("C ucnt 3", int'(ucnt1), 3);
    force dut1.ucnt_q = 16'hFFFF;
    step();
    release dut1.ucnt_q;
    run_to(70);
    chk("C ucnt sat", int'(ucnt1), 32'hFFFF);
`endif
    run_to(100);
    chk("C rd count", rd3.size(), 1);
    chk("C rd first", at(rd3, 0), 16);
    chk("C discard", win(1, 17, 32), 8);
    chk("C new duty", win(1, 33, 48), 4);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
